color_input_conditioner: RTL

COLOR_INPUT_CONDITIONER -- requirements
Module: color_input_conditioner

---
 rtl/color_input_conditioner_pkg.sv | 37 +++
 rtl/button_debounce.sv | 45 ++++
 rtl/color_input_conditioner.sv | 104 ++++++++++
 3 files changed

// File: rtl/color_input_conditioner_pkg.sv
// Shared game types: button color codes, input-FSM states and debounce sizing.
// The controller imports the same package for its view of colors and states.
package color_input_conditioner_pkg;

  localparam int unsigned DB_CNT_W = 8;

  localparam int unsigned CH_GREEN  = 0;
  localparam int unsigned CH_RED    = 1;
  localparam int unsigned CH_BLUE   = 2;
  localparam int unsigned CH_YELLOW = 3;
  localparam int unsigned CH_START  = 4;
  localparam int unsigned NUM_CH    = 5;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    RED    = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_e;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LOCKOUT
  } game_input_state_e;

  // Only meaningful when exactly one bit of rise is set.
  function automatic color_e color_from_rise(input logic [3:0] rise);
    color_e c;
    c = GREEN;
    if (rise[CH_RED])    c = RED;
    if (rise[CH_BLUE])   c = BLUE;
    if (rise[CH_YELLOW]) c = YELLOW;
    return c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on the debounced 0->1 transition.
module button_debounce
  import color_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This sample would bring the count to DEBOUNCE_CYCLES: accept it.
        cnt   <= '0;
        level <= sync_q2;
        rise  <= sync_q2;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/color_input_conditioner.sv
// Conditions the four color buttons and start button into clean one-cycle
// events for the game controller, rejecting overlapping color presses.
module color_input_conditioner
  import color_input_conditioner_pkg::*;
#(
  parameter int unsigned COLOR_CODEFY_W  = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      button_color_green,
  input  logic                      button_color_red,
  input  logic                      button_color_blue,
  input  logic                      button_color_yellow,
  input  logic                      start,
  input  logic                      enable,
  output logic                      color_valid,
  output logic [COLOR_CODEFY_W-1:0] color_code,
  output logic                      start_pulse,
  output logic                      multi_press
);

  logic raw   [NUM_CH];
  logic lvl   [NUM_CH];
  logic rise  [NUM_CH];

  logic [3:0]        color_rise;
  logic [2:0]        rise_cnt;
  logic              any_color_level;
  color_e            rise_color;
  game_input_state_e state;

  always_comb begin
    raw[CH_GREEN]  = button_color_green;
    raw[CH_RED]    = button_color_red;
    raw[CH_BLUE]   = button_color_blue;
    raw[CH_YELLOW] = button_color_yellow;
    raw[CH_START]  = start;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    color_rise      = {rise[CH_YELLOW], rise[CH_BLUE], rise[CH_RED], rise[CH_GREEN]};
    rise_cnt        = 3'(color_rise[0]) + 3'(color_rise[1])
                    + 3'(color_rise[2]) + 3'(color_rise[3]);
    any_color_level = lvl[CH_GREEN] | lvl[CH_RED] | lvl[CH_BLUE] | lvl[CH_YELLOW];
    rise_color      = color_from_rise(color_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      color_valid <= 1'b0;
      color_code  <= '0;
      start_pulse <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      multi_press <= 1'b0;
      start_pulse <= rise[CH_START];
      case (state)
        IDLE: begin
          if (rise_cnt >= 3'd2) begin
            multi_press <= 1'b1;
            state       <= LOCKOUT;
          end else if (rise_cnt == 3'd1) begin
            if (enable) begin
              color_valid <= 1'b1;
              color_code  <= COLOR_CODEFY_W'(rise_color);
              state       <= PRESSED;
            end else begin
              state <= LOCKOUT;
            end
          end
        end
        PRESSED: begin
          // A new press outranks a same-cycle release of the held button.
          if (rise_cnt != 3'd0) begin
            multi_press <= 1'b1;
            state       <= LOCKOUT;
          end else if (!any_color_level) begin
            state <= IDLE;
          end
        end
        LOCKOUT: begin
          if (!any_color_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
